// File: rtl/latch_wr_seq_if.sv
// Request handshake between a client and the latch write sequencer.
// The master drives valid/clr/data. The slave (the sequencer) drives ready.
interface latch_wr_seq_if #(
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_clr;
    logic [DW-1:0] req_data;

    modport master (
        output req_valid,
        output req_clr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_clr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/latch_wr_seq.sv
// Write sequencer for a bank of level-sensitive D latches.
// It takes write or clear requests over a valid/ready handshake and drives
// the latch pins through a setup / open / hold window. Every output is
// registered, so the latch pins cannot glitch between requests.
//
// Optional readback verify: define LATCH_WR_VERIFY_EN.
//   When the macro is undefined, err is tied low and lat_q is ignored.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for a request; lat_d holds the last value driven
// SETUP   | lat_d driven with the new value (or 0 for a clear); latch closed
// OPEN    | write: lat_en high; clear: lat_rstn low
// HOLD    | latch closed; lat_d held; done on exit
module latch_wr_seq #(
    parameter int DW        = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic          clk,
    input  logic          rstn,
    latch_wr_seq_if.slave req,
    output logic [DW-1:0] lat_d,
    output logic          lat_en,
    output logic          lat_rstn,
    input  logic [DW-1:0] lat_q,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int MAX_SO  = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int MAX_CYC = (MAX_SO > HOLD_CYC) ? MAX_SO : HOLD_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    // A zero-length window would skip a phase of the latch protocol.
    if (SETUP_CYC < 1 || OPEN_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cyc
        $error("latch_wr_seq: SETUP_CYC, OPEN_CYC and HOLD_CYC must all be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_OPEN,
        ST_HOLD
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          clr_q, clr_nxt;
    logic [DW-1:0] lat_d_nxt;
    logic          lat_en_nxt;
    logic          lat_rstn_nxt;
    logic          ready_q, ready_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          err_nxt;
    logic          cnt_last;
    logic          mismatch;

    assign cnt_last      = (cnt == '0);
    assign req.req_ready = ready_q;

`ifdef LATCH_WR_VERIFY_EN
    // lat_d always holds the expected latch content: the written data, or 0 for a clear.
    assign mismatch = (lat_q != lat_d);
`else
    logic unused_lat_q;
    assign unused_lat_q = ^lat_q;
    assign mismatch     = 1'b0;
`endif

    // Next-state and next-output decode. Every output is registered from these values.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        clr_nxt      = clr_q;
        lat_d_nxt    = lat_d;
        lat_en_nxt   = lat_en;
        lat_rstn_nxt = lat_rstn;
        ready_nxt    = ready_q;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;

        case (state)
            ST_IDLE: begin
                lat_en_nxt   = 1'b0;
                lat_rstn_nxt = 1'b1;
                ready_nxt    = 1'b1;
                busy_nxt     = 1'b0;
                if (req.req_valid && ready_q) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = CW'(SETUP_CYC - 1);
                    clr_nxt   = req.req_clr;
                    lat_d_nxt = req.req_clr ? '0 : req.req_data;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_last) begin
                    state_nxt    = ST_OPEN;
                    cnt_nxt      = CW'(OPEN_CYC - 1);
                    lat_en_nxt   = !clr_q;
                    lat_rstn_nxt = !clr_q;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_OPEN: begin
                if (cnt_last) begin
                    state_nxt    = ST_HOLD;
                    cnt_nxt      = CW'(HOLD_CYC - 1);
                    lat_en_nxt   = 1'b0;
                    lat_rstn_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_last) begin
                    state_nxt = ST_IDLE;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    err_nxt   = mismatch;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any sequence in flight and issues no done.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            clr_q    <= 1'b0;
            lat_d    <= '0;
            lat_en   <= 1'b0;
            lat_rstn <= 1'b0;
            ready_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            clr_q    <= clr_nxt;
            lat_d    <= lat_d_nxt;
            lat_en   <= lat_en_nxt;
            lat_rstn <= lat_rstn_nxt;
            ready_q  <= ready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

`ifdef LATCH_WR_VERIFY_EN
    // Registered compare result. It is valid in the same cycle as done.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err <= 1'b0;
        end else begin
            err <= err_nxt;
        end
    end
`else
    logic unused_err_nxt;
    assign unused_err_nxt = err_nxt;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_latch_wr_seq.sv
// Directed bench for latch_wr_seq with SETUP=2, OPEN=3, HOLD=1.
// A behavioural D latch sits on the lat_* pins and drives lat_q back.
module tb_latch_wr_seq;

    localparam int DW = 8;

    logic          clk;
    logic          rstn;
    logic [DW-1:0] lat_d;
    logic          lat_en;
    logic          lat_rstn;
    logic [DW-1:0] lat_q;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] q_model;
    logic          force_bad;

    int n_chk;
    int n_err;

    latch_wr_seq_if #(.DW(DW)) req_if ();

    latch_wr_seq #(
        .DW        (DW),
        .SETUP_CYC (2),
        .OPEN_CYC  (3),
        .HOLD_CYC  (1)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req_if.slave),
        .lat_d    (lat_d),
        .lat_en   (lat_en),
        .lat_rstn (lat_rstn),
        .lat_q    (lat_q),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level-sensitive D latch with active-low reset.
    always_latch begin
        if (!lat_rstn)
            q_model <= '0;
        else if (lat_en)
            q_model <= lat_d;
    end

    assign lat_q = force_bad ? '0 : q_model;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctrl_now();
        return {req_if.req_ready, busy, lat_en, lat_rstn, done, err};
    endfunction

    // Runs one request from acceptance through to the done cycle and checks every cycle.
    // Cycle c is sampled on the falling edge after accept edge T + (c-1).
    task automatic run_seq(input string tag, input logic clr, input logic [7:0] data,
                           input logic exp_err);
        logic       en_e, rs_e, dn_e;
        logic [5:0] exp_c;
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_clr   = clr;
        req_if.req_data  = data;
        chk({tag, " ready_before"}, 32'(req_if.req_ready), 32'd1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) req_if.req_valid = 1'b0;
            en_e  = !clr && (c >= 3) && (c <= 5);
            rs_e  = !(clr && (c >= 3) && (c <= 5));
            dn_e  = (c == 7);
            exp_c = {dn_e, !dn_e, en_e, rs_e, dn_e, dn_e && exp_err};
            chk($sformatf("%s ctrl c%0d", tag, c), 32'(ctrl_now()), 32'(exp_c));
            chk($sformatf("%s lat_d c%0d", tag, c), 32'(lat_d), 32'(clr ? 8'h00 : data));
        end
        chk({tag, " latch_q"}, 32'(q_model), 32'(clr ? 8'h00 : data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int       done_cnt, en_win, first_done, second_done;
        logic     prev_en;
        logic     en_e, dn_e;
        logic [7:0] d_e;

        n_chk            = 0;
        n_err            = 0;
        force_bad        = 1'b0;
        rstn             = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_clr   = 1'b0;
        req_if.req_data  = '0;

        // Reset held for three edges; every output stays low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset ctrl %0d", i), 32'(ctrl_now()), 32'h00);
            chk($sformatf("reset lat_d %0d", i), 32'(lat_d), 32'h00);
        end
        rstn = 1'b1;
        @(negedge clk);
        chk("release ctrl", 32'(ctrl_now()), 32'(6'b100100));
        chk("release lat_d", 32'(lat_d), 32'h00);

        run_seq("wr_a5", 1'b0, 8'hA5, 1'b0);
        @(negedge clk);
        chk("idle keeps lat_d", 32'(lat_d), 32'hA5);
        chk("idle ctrl", 32'(ctrl_now()), 32'(6'b100100));

        run_seq("clr", 1'b1, 8'hFF, 1'b0);

        // Back-to-back with req_valid held: the second request is taken in the done cycle.
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_clr   = 1'b0;
        req_if.req_data  = 8'h3C;
        done_cnt    = 0;
        en_win      = 0;
        first_done  = 0;
        second_done = 0;
        prev_en     = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) req_if.req_data = 8'hC3;
            if (c == 8) req_if.req_valid = 1'b0;
            en_e = ((c >= 3) && (c <= 5)) || ((c >= 10) && (c <= 12));
            dn_e = (c == 7) || (c == 14);
            d_e  = (c <= 7) ? 8'h3C : 8'hC3;
            chk($sformatf("b2b ctrl c%0d", c), 32'(ctrl_now()), 32'({dn_e, !dn_e, en_e, 1'b1, dn_e, 1'b0}));
            chk($sformatf("b2b lat_d c%0d", c), 32'(lat_d), 32'(d_e));
            if (lat_en && !prev_en) en_win++;
            prev_en = lat_en;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) first_done = c;
                else second_done = c;
            end
        end
        chk("b2b done count", 32'(done_cnt), 32'd2);
        chk("b2b en windows", 32'(en_win), 32'd2);
        chk("b2b done spacing", 32'(second_done - first_done), 32'd7);
        chk("b2b latch_q", 32'(q_model), 32'hC3);

        // Reset asserted in the second OPEN cycle aborts the sequence.
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_data  = 8'h77;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) req_if.req_valid = 1'b0;
        end
        chk("abort en before", 32'(lat_en), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort ctrl", 32'(ctrl_now()), 32'h00);
        chk("abort lat_d", 32'(lat_d), 32'h00);
        rstn = 1'b1;
        @(negedge clk);
        chk("abort release ctrl", 32'(ctrl_now()), 32'(6'b100100));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("abort no done %0d", i), 32'(done), 32'd0);
        end

        run_seq("wr_after_abort", 1'b0, 8'h96, 1'b0);

`ifdef LATCH_WR_VERIFY_EN
        // Readback stuck at zero must flag err on a write of 0x5A.
        force_bad = 1'b1;
        run_seq("verify_bad", 1'b0, 8'h5A, 1'b1);
        force_bad = 1'b0;
        run_seq("verify_good", 1'b0, 8'h5A, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/latch_wr_seq.md
# latch_wr_seq

Write sequencer that sits directly upstream of a bank of level-sensitive D latches (data `d`, enable `en`, active-low reset `rstn`). It accepts write or clear requests over a valid/ready handshake and drives the latch pins with a programmed setup / open / hold window. `lat_d` is stable before `lat_en` rises and after it falls, and no latch-pin glitches occur between requests. An optional verify stage reads the latch output back and flags mismatches.

## Interface
- `DW`, 8: latch data width.
- `SETUP_CYC`, 1: cycles `lat_d` is stable before the open window (≥1).
- `OPEN_CYC`, 2: cycles the open window lasts (≥1).
- `HOLD_CYC`, 1: cycles `lat_d` is held after the open window (≥1).
- `clk` input 1: rising-edge clock.
- `rstn` input 1: reset, synchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: sequencer can accept a request.
- `req_clr` input 1: request is a clear; `req_data` is ignored.
- `req_data` input DW: value to latch.
- `lat_d` output DW: latch data pins.
- `lat_en` output 1: latch enable.
- `lat_rstn` output 1: latch reset, active-low.
- `lat_q` input DW: latch readback. Used only with verify; otherwise unused.
- `busy` output 1: sequence in progress.
- `done` output 1: one-cycle pulse at the end of a sequence.
- `err` output 1: one-cycle pulse with `done` on verify mismatch. Tied to 0 when verify is not built.

## Operation
- All outputs are registered. No combinational path from inputs to the `lat_*` outputs.
- States: IDLE → SETUP → OPEN → HOLD → IDLE.
- A single down-counter, sized to `$clog2(max(SETUP_CYC, OPEN_CYC, HOLD_CYC)+1)`, is loaded on each state entry.
- **IDLE**
  - `req_ready`=1, `busy`=0.
  - On `req_valid` && `req_ready`: capture `req_data` and `req_clr`, then go to SETUP.
- **SETUP** (`SETUP_CYC` cycles)
  - Write: `lat_d` = captured data.
  - Clear: `lat_d` = 0.
  - `lat_en`=0 and `lat_rstn`=1 in both cases.
- **OPEN** (`OPEN_CYC` cycles)
  - Write: `lat_en`=1.
  - Clear: `lat_rstn`=0 and `lat_en`=0.
  - `lat_d` is unchanged.
- **HOLD** (`HOLD_CYC` cycles)
  - `lat_en`=0, `lat_rstn`=1, `lat_d` unchanged.
  - On the last HOLD cycle, go to IDLE and pulse `done` on the next cycle.
- `lat_d` keeps its last value in IDLE. It changes only on entry to SETUP.
- `req_valid` during a sequence is ignored (`req_ready`=0). The request is held off, not dropped, by the handshake.
- A request arriving the same cycle `done` pulses is accepted, so back-to-back sequences run with zero bubble beyond the IDLE cycle.
- Elaboration fails if any `*_CYC` parameter is 0.

## Timing
- Reset values:
  - `req_ready`=0, `lat_d`=0, `lat_en`=0, `lat_rstn`=0, `busy`=0, `done`=0, `err`=0.
  - State is IDLE.
- After release: `lat_rstn` and `req_ready` rise on the first clock edge with `rstn`=1.
- Reset mid-sequence: at the next edge, the sequence is aborted and all outputs take their reset values. No `done` is issued for the aborted request.
- Timeline for a request accepted at edge T:
  - SETUP covers edges T+1 … T+SETUP_CYC.
  - `lat_en` is high for exactly `OPEN_CYC` cycles.
  - `done` is high in the cycle after edge T+SETUP_CYC+OPEN_CYC+HOLD_CYC.
  - `req_ready` is high in that same cycle.
- `busy` equals `!req_ready` outside reset.

## Configuration
- Macro: `LATCH_WR_VERIFY_EN`.
- Defined:
  - On the last HOLD cycle, `lat_q` is registered and compared with the expected value (captured data for a write, 0 for a clear).
  - On mismatch, `err` pulses in the same cycle as `done`.
  - `lat_q` is the only port of the verify path.
- Undefined:
  - Compare logic is absent.
  - `err` is constant 0.
  - `lat_q` is unconnected internally.
  - Sequence timing is identical in both builds.

## Test plan
All scenarios use `DW`=8, `SETUP_CYC`=2, `OPEN_CYC`=3, `HOLD_CYC`=1 unless stated.

- **Reset:** hold `rstn`=0 for 3 cycles, then release.
  - All outputs are 0 during reset.
  - `lat_rstn`=1 and `req_ready`=1 one edge after release.
- **Write 0xA5:** accepted at T.
  - `lat_d`=0xA5 from T+1.
  - `lat_en`=1 exactly during cycles T+3…T+5.
  - `done`=1 in cycle T+7.
  - Latch model `q`=0xA5.
- **Clear after write:**
  - `lat_rstn`=0 for 3 cycles.
  - `lat_en` stays 0.
  - `lat_d`=0x00.
  - Latch model `q`=0x00.
  - `done` pulses once.
- **Back-to-back:** write 0x3C, then 0xC3 with `req_valid` held continuously.
  - Second request is accepted in the `done` cycle.
  - Two `done` pulses, 7 cycles apart.
  - Only two `lat_en` windows.
- **Reset at second OPEN cycle:**
  - `lat_en` falls at the next edge.
  - No `done`.
  - `req_ready` is 1 one edge after release.
- **Verify build (`LATCH_WR_VERIFY_EN`):** latch model forces `q`=0x00 on a write of 0x5A.
  - `err`=1 coincident with `done`.
  - With a correct model, `err` stays 0.
